lin_accum: RTL

Fully-connected accumulation stage directly downstream of the 2x2 pooling stage. Each valid beat carries three pooled bytes from each of three channels (nine unsigned values). The block multiplies them by nine signed weights, accumulates over a fixed number of beats per frame, adds a bias, and requantizes. It emits one 8-bit ReLU-clamped neuron output per frame, with a single-cycle valid pulse.

---
 rtl/lin_accum.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lin_accum.sv
// Fully-connected accumulation stage: nine byte*weight products per beat, accumulated
// over N_BEATS beats plus bias, then requantized to one ReLU-clamped byte per frame.
module lin_accum #(
    parameter int N_BEATS = 16,
    parameter int ACC_W   = 32,
    parameter int SHIFT   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [23:0]                pool_lin_D1,
    input  logic [23:0]                pool_lin_D2,
    input  logic [23:0]                pool_lin_D3,
    input  logic [71:0]                wt,
    input  logic [15:0]                bias,
    input  logic                       clr,
    output logic [$clog2(N_BEATS)-1:0] beat_idx,
    output logic [7:0]                 out_data,
    output logic                       out_vld
);

    localparam int IDX_W = $clog2(N_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BEATS - 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             accept;
    logic             is_first;
    logic             is_last;

    logic [71:0]        pix;
    logic signed [16:0] prod_d [9];
    logic signed [16:0] prod_q [9];
    logic               s1_vld_q, s1_first_q, s1_last_q;
    logic [15:0]        s1_bias_q;

    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic                    s2_last_q;

    logic signed [ACC_W-1:0] quant;
    logic [7:0]              sat_d;
    logic [7:0]              out_data_q;
    logic                    out_vld_q;

    assign accept = in_vld & ~clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (accept) state_d = ACC;
            ACC:  if (accept && idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        if (clr) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    // IDLE always coincides with beat index 0, so state alone marks the first beat.
    always_comb begin
        is_first = 1'b0;
        is_last  = 1'b0;
        case (state_q)
            IDLE: is_first = 1'b1;
            ACC:  is_last  = (idx_q == LAST_IDX);
            default: ;
        endcase
    end

    assign pix = {pool_lin_D3, pool_lin_D2, pool_lin_D1};

    always_comb begin
        for (int unsigned j = 0; j < 9; j++) begin
            prod_d[j] = 17'($signed({1'b0, pix[8*j +: 8]})) * 17'($signed(wt[8*j +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_vld_q   <= accept;
            s1_first_q <= accept & is_first;
            s1_last_q  <= accept & is_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_bias_q <= '0;
            for (int unsigned j = 0; j < 9; j++) prod_q[j] <= '0;
        end else if (accept) begin
            s1_bias_q <= bias;
            for (int unsigned j = 0; j < 9; j++) prod_q[j] <= prod_d[j];
        end
    end

    always_comb begin
        sum_d = '0;
        for (int unsigned j = 0; j < 9; j++) begin
            sum_d = sum_d + {{(ACC_W-17){prod_q[j][16]}}, prod_q[j]};
        end
    end

    assign bias_ext = {{(ACC_W-16){s1_bias_q[15]}}, s1_bias_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            s2_last_q <= 1'b0;
        end else begin
            s2_last_q <= s1_vld_q & s1_last_q & ~clr;
            if (s1_vld_q && !clr) begin
                acc_q <= s1_first_q ? bias_ext + sum_d : acc_q + sum_d;
            end
        end
    end

    assign quant = acc_q >>> SHIFT;

    always_comb begin
        if (quant[ACC_W-1]) begin
            sat_d = '0;
        end else if (|quant[ACC_W-2:8]) begin
            sat_d = '1;
        end else begin
            sat_d = quant[7:0];
        end
    end

    // A result already in this stage still emits even when clr arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            out_vld_q <= s2_last_q;
            if (s2_last_q) out_data_q <= sat_d;
        end
    end

    assign beat_idx = idx_q;
    assign out_data = out_data_q;
    assign out_vld  = out_vld_q;

endmodule
